// File: rtl/mlp_batch_sequencer_if.sv
// Control/result bundle between the batch host and mlp_batch_sequencer.
// master: host side (drives run_req/batch_len/abort and the core's done/class).
// slave : sequencer side (drives core_start, image index, results, statistics).
interface mlp_batch_sequencer_if #(
  parameter int unsigned CLASS_W = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CNT_W   = 32
);
  logic               run_req;
  logic [IDX_W-1:0]   batch_len;
  logic               abort;
  logic               core_start;
  logic               core_done;
  logic [CLASS_W-1:0] core_class;
  logic [IDX_W-1:0]   img_idx;
  logic               busy;
  logic               result_valid;
  logic [IDX_W-1:0]   result_idx;
  logic [CLASS_W-1:0] result_class;
  logic [CNT_W-1:0]   result_cycles;
  logic               batch_done;
  logic               timeout_err;
  logic               aborted;
  logic [CNT_W-1:0]   min_cycles;
  logic [CNT_W-1:0]   max_cycles;
  logic [CNT_W-1:0]   total_cycles;

  modport master (
    output run_req, batch_len, abort, core_done, core_class,
    input  core_start, img_idx, busy, result_valid, result_idx, result_class,
           result_cycles, batch_done, timeout_err, aborted,
           min_cycles, max_cycles, total_cycles
  );

  modport slave (
    input  run_req, batch_len, abort, core_done, core_class,
    output core_start, img_idx, busy, result_valid, result_idx, result_class,
           result_cycles, batch_done, timeout_err, aborted,
           min_cycles, max_cycles, total_cycles
  );
endinterface

// File: rtl/mlp_batch_sequencer.sv
// Batch inference sequencer in front of mlp_top.
// Issues one core_start per image of a programmable batch, captures each
// predicted class with its start-to-done latency, keeps min/max/total latency
// statistics and a per-inference timeout watchdog.
// Ports: clk (rising edge), reset (synchronous, active high),
//        bus (mlp_batch_sequencer_if.slave: host control, core handshake,
//        per-image results, batch status and statistics).
module mlp_batch_sequencer #(
  parameter int unsigned CLASS_W = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  mlp_batch_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_FINISH} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   len_q, img_idx_q, result_idx_q;
  logic [CLASS_W-1:0] result_class_q;
  logic [CNT_W-1:0]   lat, result_cycles_q, min_q, max_q, total_q;
  logic               result_valid_q, timeout_q, aborted_q;
  logic               do_accept, do_capture, do_timeout, do_abort;
  logic               more_images;
  logic [CNT_W:0]     total_sum;

  // Widened compare so img_idx+1 cannot wrap when batch_len is the maximum.
  assign more_images = ({1'b0, img_idx_q} + (IDX_W+1)'(1)) < {1'b0, len_q};
  assign total_sum   = {1'b0, total_q} + {1'b0, lat};

  always_comb begin
    state_n    = state;
    do_accept  = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    do_abort   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.run_req) begin
          do_accept = 1'b1;
          state_n   = (bus.batch_len == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.abort) begin
          do_abort = 1'b1;
          state_n  = S_FINISH;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // abort > done > timeout
        if (bus.abort) begin
          do_abort = 1'b1;
          state_n  = S_FINISH;
        end else if (bus.core_done) begin
          do_capture = 1'b1;
          state_n    = S_GAP;
        end else if (lat == TIMEOUT_C) begin
          do_timeout = 1'b1;
          state_n    = S_FINISH;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          do_abort = 1'b1;
          state_n  = S_FINISH;
        end else if (!bus.core_done) begin
          state_n = more_images ? S_LAUNCH : S_FINISH;
        end
      end
      // The batch is already ending here; abort has nothing left to stop,
      // so FINISH always proceeds to IDLE with a single batch_done.
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      len_q           <= '0;
      img_idx_q       <= '0;
      lat             <= '0;
      result_valid_q  <= 1'b0;
      result_idx_q    <= '0;
      result_class_q  <= '0;
      result_cycles_q <= '0;
      timeout_q       <= 1'b0;
      aborted_q       <= 1'b0;
      min_q           <= '1;
      max_q           <= '0;
      total_q         <= '0;
    end else begin
      state          <= state_n;
      result_valid_q <= do_capture;

      if (do_accept) begin
        len_q     <= bus.batch_len;
        img_idx_q <= '0;
        timeout_q <= 1'b0;
        aborted_q <= 1'b0;
        min_q     <= '1;
        max_q     <= '0;
        total_q   <= '0;
      end

      if (state == S_LAUNCH) begin
        lat <= CNT_W'(1);
      end else if (state == S_WAIT && lat != '1) begin
        lat <= lat + CNT_W'(1);
      end

      if (do_capture) begin
        result_idx_q    <= img_idx_q;
        result_class_q  <= bus.core_class;
        result_cycles_q <= lat;
        if (lat < min_q) min_q <= lat;
        if (lat > max_q) max_q <= lat;
        total_q <= total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
      end

      if (do_timeout) timeout_q <= 1'b1;
      if (do_abort)   aborted_q <= 1'b1;

      if (state == S_GAP && state_n == S_LAUNCH) begin
        img_idx_q <= img_idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.core_start    = (state == S_LAUNCH);
  assign bus.busy          = (state != S_IDLE);
  assign bus.batch_done    = (state == S_FINISH);
  assign bus.img_idx       = img_idx_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_idx    = result_idx_q;
  assign bus.result_class  = result_class_q;
  assign bus.result_cycles = result_cycles_q;
  assign bus.timeout_err   = timeout_q;
  assign bus.aborted       = aborted_q;
  assign bus.min_cycles    = min_q;
  assign bus.max_cycles    = max_q;
  assign bus.total_cycles  = total_q;

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Scoreboard bench for mlp_batch_sequencer: a behavioural core model answers
// each core_start according to a per-image plan, the stimulus pushes the
// expected results and end-of-batch status into queues, and a monitor pops
// and compares them whenever the DUT presents result_valid or batch_done.
module tb_mlp_batch_sequencer;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TMO     = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mlp_batch_sequencer_if #(.CLASS_W(CLASS_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  mlp_batch_sequencer #(
    .CLASS_W(CLASS_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int unsigned        k;    // cycles from core_start to first done
    int unsigned        h;    // cycles done is held high
    logic [CLASS_W-1:0] cls;
    bit                 ab;   // raise abort together with the first done cycle
  } plan_t;
  typedef struct { longint unsigned idx, cls, cyc; } res_t;
  typedef struct { longint unsigned mn, mx, tot; bit tmo, ab; } end_t;

  plan_t batch[$];
  plan_t plan_q[$];
  res_t  exp_res_q[$];
  end_t  exp_end_q[$];

  int unsigned     n_cmp = 0, n_fail = 0;
  longint unsigned cyc = 0;
  longint unsigned exp_start_cyc = 0;
  longint unsigned bd_cyc = 0;
  int unsigned     n_starts = 0;
  int unsigned     bd_count = 0;
  bit              core_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Core model: answers each core_start from the plan queue.
  initial begin
    plan_t p;
    bus.core_done  = 1'b0;
    bus.core_class = '0;
    bus.abort      = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        n_starts++;
        check("start_cycle", cyc, exp_start_cyc);
        check("busy_at_start", bus.busy, 1);
        check("img_idx_at_start", bus.img_idx, n_starts - 1);
        if (plan_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_core_start: start with no planned image (cycle %0d)", cyc);
        end else begin
          p = plan_q.pop_front();
          core_busy = 1'b1;
          exp_start_cyc = cyc + p.k + p.h + 1;
          for (int unsigned j = 1; j <= p.k + p.h; j++) begin
            @(posedge clk);
            #1;
            bus.core_done  = (j >= p.k) && (j < p.k + p.h);
            bus.core_class = bus.core_done ? p.cls : CLASS_W'($urandom);
            bus.abort      = p.ab && (j == p.k);
          end
          core_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    res_t r;
    end_t e;
    forever begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: idx %0d class %0d cycles %0d, none expected",
                   bus.result_idx, bus.result_class, bus.result_cycles);
        end else begin
          r = exp_res_q.pop_front();
          check("result_idx", bus.result_idx, r.idx);
          check("result_class", bus.result_class, r.cls);
          check("result_cycles", bus.result_cycles, r.cyc);
        end
      end
      if (bus.batch_done === 1'b1) begin
        bd_count++;
        bd_cyc = cyc;
        if (exp_end_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_batch_done: got batch_done, none expected (cycle %0d)", cyc);
        end else begin
          e = exp_end_q.pop_front();
          check("min_cycles", bus.min_cycles, e.mn);
          check("max_cycles", bus.max_cycles, e.mx);
          check("total_cycles", bus.total_cycles, e.tot);
          check("timeout_err", bus.timeout_err, e.tmo);
          check("aborted", bus.aborted, e.ab);
          check("results_outstanding", exp_res_q.size(), 0);
        end
      end
    end
  end

  task automatic wait_core_idle();
    for (int i = 0; i < 200 && core_busy; i++) @(posedge clk);
    if (core_busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL core_idle_wait: core model still busy after 200 cycles");
    end
  endtask

  task automatic check_reset_values();
    check("rst_core_start", bus.core_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_img_idx", bus.img_idx, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result_idx", bus.result_idx, 0);
    check("rst_result_class", bus.result_class, 0);
    check("rst_result_cycles", bus.result_cycles, 0);
    check("rst_batch_done", bus.batch_done, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_min_cycles", bus.min_cycles, 64'hFFFF_FFFF);
    check("rst_max_cycles", bus.max_cycles, 0);
    check("rst_total_cycles", bus.total_cycles, 0);
  endtask

  // Runs the images in 'batch': reference model first, then the stimulus.
  task automatic run_batch();
    end_t            e;
    res_t            r;
    int unsigned     attempted = 0;
    int unsigned     bd0;
    longint unsigned c0;
    bit              stop = 1'b0;
    wait_core_idle();
    e.mn = 64'hFFFF_FFFF; e.mx = 0; e.tot = 0; e.tmo = 1'b0; e.ab = 1'b0;
    foreach (batch[i]) begin
      if (!stop) begin
        attempted++;
        plan_q.push_back(batch[i]);
        if (batch[i].k > TMO) begin
          e.tmo = 1'b1;
          stop  = 1'b1;
        end else if (batch[i].ab) begin
          e.ab = 1'b1;
          stop = 1'b1;
        end else begin
          r.idx = i; r.cls = batch[i].cls; r.cyc = batch[i].k;
          exp_res_q.push_back(r);
          if (r.cyc < e.mn) e.mn = r.cyc;
          if (r.cyc > e.mx) e.mx = r.cyc;
          e.tot += r.cyc;
        end
      end
    end
    exp_end_q.push_back(e);
    n_starts = 0;
    @(posedge clk);
    #1;
    bus.batch_len = IDX_W'(batch.size());
    bus.run_req   = 1'b1;
    c0            = cyc;
    exp_start_cyc = c0 + 1;
    bd0           = bd_count;
    @(posedge clk);
    #1;
    bus.run_req   = 1'b0;
    bus.batch_len = IDX_W'($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (bd_count != bd0) break;
    end
    if (bd_count == bd0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL batch_done_wait: no batch_done within 3000 cycles (len %0d)", batch.size());
    end else begin
      if (batch.size() == 0) check("empty_batch_done_cycle", bd_cyc, c0 + 1);
      @(negedge clk);
      check("busy_after_batch_done", bus.busy, 0);
    end
    wait_core_idle();
    check("core_start_count", n_starts, attempted);
    plan_q.delete();
    exp_res_q.delete();
    batch.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, k;
    reset         = 1'b1;
    bus.run_req   = 1'b0;
    bus.batch_len = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Single image, done at k=5 with class 7.
    batch.push_back('{k:5, h:1, cls:7, ab:0});
    run_batch();
    // Batch of three, latencies 4/7/5.
    batch.push_back('{k:4, h:1, cls:2, ab:0});
    batch.push_back('{k:7, h:1, cls:9, ab:0});
    batch.push_back('{k:5, h:1, cls:13, ab:0});
    run_batch();
    // Held-level done for 4 cycles.
    batch.push_back('{k:3, h:4, cls:5, ab:0});
    batch.push_back('{k:6, h:4, cls:11, ab:0});
    run_batch();
    // Core never responds within TIMEOUT.
    batch.push_back('{k:TMO + 5, h:1, cls:1, ab:0});
    run_batch();
    // Done exactly at lat=TIMEOUT wins over timeout.
    batch.push_back('{k:TMO, h:1, cls:4, ab:0});
    batch.push_back('{k:TMO + 1, h:1, cls:6, ab:0});
    run_batch();
    // Abort coincident with done on image 1 of 3.
    batch.push_back('{k:4, h:1, cls:3, ab:0});
    batch.push_back('{k:6, h:1, cls:8, ab:1});
    batch.push_back('{k:5, h:1, cls:10, ab:0});
    run_batch();
    // Empty batch.
    run_batch();

    // Reset in the middle of WAIT.
    wait_core_idle();
    n_starts = 0;
    plan_q.push_back('{k:10, h:1, cls:12, ab:0});
    @(posedge clk);
    #1;
    bus.batch_len = 2;
    bus.run_req   = 1'b1;
    exp_start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    bus.run_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    wait_core_idle();
    plan_q.delete();
    // Normal operation afterwards.
    batch.push_back('{k:2, h:1, cls:15, ab:0});
    batch.push_back('{k:1, h:2, cls:0, ab:0});
    run_batch();

    // Randomised batches.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 5);
      for (int unsigned i = 0; i < n; i++) begin
        k = $urandom_range(1, TMO + 2);
        batch.push_back('{k:k, h:$urandom_range(1, 4), cls:CLASS_W'($urandom),
                          ab:(k <= TMO) && ($urandom_range(0, 9) == 0)});
      end
      run_batch();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
